mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 25 ++
 rtl/mem_arb_pick.sv | 42 ++++
 rtl/mem_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and default sizing for the instruction/data memory port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_port_arbiter_pkg;

  localparam int DEF_ADDR_W       = 10;
  localparam int DEF_MEM_LAT      = 2;
  localparam int DEF_STARVE_LIMIT = 2;

  // Access sequencer states: 2-bit encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Which requester currently owns the memory port
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between fetch (I) and data (D) requests.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller only consumes the result in a grant cycle.
// Optional feature macro: MEM_ARB_FAIRNESS_EN (starvation override lets I win).
module mem_arb_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
  input  logic   starve_hit,
  output logic   grant_vld,
  output owner_t grant_own
);

`ifdef MEM_ARB_FAIRNESS_EN
  // D has priority unless the fetch side has been passed over too many times
  always_comb begin
    grant_own = OWN_NONE;
    if (i_req && (starve_hit || !d_req)) begin
      grant_own = OWN_I;
    end else if (d_req) begin
      grant_own = OWN_D;
    end
  end
`else
  logic unused_starve;
  assign unused_starve = starve_hit;

  // Fixed priority: D always beats I
  always_comb begin
    grant_own = OWN_NONE;
    if (d_req) begin
      grant_own = OWN_D;
    end else if (i_req) begin
      grant_own = OWN_I;
    end
  end
`endif

  assign grant_vld = i_req | d_req;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between an instruction-fetch and a data requester.
// Latency: request seen in cycle N -> ack in cycle N+1+MEM_LAT; back-to-back grants from RESP.
// Backpressure: requesters hold req/addr/data until their one-cycle ack; loser waits.
// Optional feature macro: MEM_ARB_FAIRNESS_EN (bounded D streak while a fetch waits).
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int MEM_LAT      = DEF_MEM_LAT,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  input  logic              i_flush,
  output logic              i_ack,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  state_t      state;
  owner_t      owner;
  logic        own_we;
  logic        flushed;
  logic [2:0]  wait_cnt;
  logic [31:0] i_rdata_q;
  logic [31:0] d_rdata_q;

  logic        arb_phase;
  logic        i_req_eff;
  logic        i_flush_own;
  logic        starve_hit;
  logic        grant_vld;
  owner_t      grant_own;

  // Upper address bits wrap away; keep them visibly consumed
  logic unused_addr;
  assign unused_addr = ^{i_addr[31:ADDR_W], d_addr[31:ADDR_W]};

  // Arbitration happens from IDLE and from RESP (back-to-back, no bubble)
  assign arb_phase   = (state == ST_IDLE) || (state == ST_RESP);
  // A branch in the grant cycle takes the fetch out of the running
  assign i_req_eff   = i_req & ~i_flush;
  assign i_flush_own = i_flush && (owner == OWN_I);

  assign busy  = (state != ST_IDLE);
  assign i_ack = (state == ST_RESP) && (owner == OWN_I) && !flushed && !i_flush;
  assign d_ack = (state == ST_RESP) && (owner == OWN_D);

  // Memory data arrives in the RESP cycle, so it is forwarded alongside the ack
  assign i_rdata = i_ack ? mem_rdata : i_rdata_q;
  assign d_rdata = (d_ack && !own_we) ? mem_rdata : d_rdata_q;

`ifdef MEM_ARB_FAIRNESS_EN
  logic [3:0] starve_cnt;
  assign starve_hit = (starve_cnt >= 4'(STARVE_LIMIT));

  // Count consecutive D grants made while a fetch is left waiting
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
    end else if (!i_req) begin
      starve_cnt <= '0;
    end else if (arb_phase && grant_vld) begin
      if (grant_own == OWN_I) begin
        starve_cnt <= '0;
      end else if (starve_cnt != 4'hF) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end
`else
  assign starve_hit = 1'b0;
  logic unused_cfg;
  assign unused_cfg = (STARVE_LIMIT == 0);
`endif

  mem_arb_pick u_pick (
    .i_req      (i_req_eff),
    .d_req      (d_req),
    .starve_hit (starve_hit),
    .grant_vld  (grant_vld),
    .grant_own  (grant_own)
  );

  // Access sequencer: grant -> ISSUE -> WAIT (MEM_LAT-1) -> RESP, registered memory drive
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      owner     <= OWN_NONE;
      own_we    <= 1'b0;
      flushed   <= 1'b0;
      wait_cnt  <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      case (state)
        ST_ISSUE: begin
          mem_en    <= 1'b0;
          mem_we    <= 1'b0;
          mem_addr  <= '0;
          mem_wdata <= '0;
          wait_cnt  <= '0;
          if (i_flush_own) flushed <= 1'b1;
          state <= (MEM_LAT == 1) ? ST_RESP : ST_WAIT;
        end
        ST_WAIT: begin
          if (i_flush_own) flushed <= 1'b1;
          if (wait_cnt == 3'(MEM_LAT - 2)) begin
            state <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end
        ST_RESP: begin
          if (i_ack) i_rdata_q <= mem_rdata;
          if (d_ack && !own_we) d_rdata_q <= mem_rdata;
        end
        default: ;
      endcase

      if (arb_phase) begin
        if (grant_vld) begin
          state   <= ST_ISSUE;
          owner   <= grant_own;
          flushed <= 1'b0;
          mem_en  <= 1'b1;
          if (grant_own == OWN_D) begin
            own_we    <= d_we;
            mem_we    <= d_we;
            mem_addr  <= d_addr[ADDR_W-1:0];
            mem_wdata <= d_wdata;
          end else begin
            own_we    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= i_addr[ADDR_W-1:0];
            mem_wdata <= '0;
          end
        end else begin
          state   <= ST_IDLE;
          owner   <= OWN_NONE;
          own_we  <= 1'b0;
          flushed <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a latency-2 memory model and an ack scoreboard.
// Expected acks (kind, cycle, data) are queued when stimulus is driven and popped on each ack.
// Build with or without MEM_ARB_FAIRNESS_EN; the starvation sequence adapts.
module tb_mem_port_arbiter;

  localparam int ADDR_W       = 10;
  localparam int MEM_LAT      = 2;
  localparam int STARVE_LIMIT = 2;

  logic              clock;
  logic              reset_n;
  logic              i_req, i_flush, i_ack;
  logic [31:0]       i_addr, i_rdata;
  logic              d_req, d_we, d_ack;
  logic [31:0]       d_addr, d_wdata, d_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;
  logic              busy;

  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc      = 0;

  typedef struct {
    bit          is_d;
    bit          chk;
    logic [31:0] data;
    int unsigned cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  logic [31:0] mem [0:1023];
  bit          written [0:1023];
  logic [31:0] rd_p0, rd_p1;

  mem_port_arbiter #(
    .ADDR_W       (ADDR_W),
    .MEM_LAT      (MEM_LAT),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_flush   (i_flush),
    .i_ack     (i_ack),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  // Unwritten words read back a fixed pattern; Mem[5] = 0x28000001
  function automatic logic [31:0] mem_pat(input logic [ADDR_W-1:0] a);
    return 32'h27FF_FFFC + {22'b0, a};
  endfunction

  function automatic logic [31:0] rd_val(input logic [ADDR_W-1:0] a);
    return written[a] ? mem[a] : mem_pat(a);
  endfunction

  // Synchronous memory: data valid MEM_LAT cycles after the mem_en cycle
  always @(posedge clock) begin
    if (mem_en && mem_we) begin
      mem[mem_addr]     <= mem_wdata;
      written[mem_addr] <= 1'b1;
    end
    rd_p0 <= mem_en ? rd_val(mem_addr) : 32'h0;
    rd_p1 <= rd_p0;
  end
  assign mem_rdata = rd_p1;

  function automatic void check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endfunction

  function automatic void push(input bit is_d, input bit chk, input logic [31:0] data,
                               input int unsigned c);
    exp_t e;
    e.is_d = is_d;
    e.chk  = chk;
    e.data = data;
    e.cyc  = c;
    sb.push_back(e);
  endfunction

  task automatic wait_ack(input bit want_d, input int budget, output bit got);
    got = 1'b0;
    for (int c = 0; c < budget && !got; c++) begin
      @(posedge clock); #1;
      got = want_d ? d_ack : i_ack;
    end
    if (want_d) check("d_ack_seen", 32'(got), 32'h1);
    else        check("i_ack_seen", 32'(got), 32'h1);
  endtask

  task automatic wait_any(input int budget, output bit got);
    got = 1'b0;
    for (int c = 0; c < budget && !got; c++) begin
      @(posedge clock); #1;
      got = i_ack | d_ack;
    end
    check("any_ack_seen", 32'(got), 32'h1);
  endtask

  task automatic step();
    @(posedge clock); #1;
  endtask

  // Scoreboard: every ack must match the oldest expectation in kind, cycle and data
  always @(negedge clock) begin
    if (mem_we) check("we_only_with_en", 32'(mem_en), 32'h1);
    if (i_ack || d_ack) begin
      check("ack_exclusive", 32'(i_ack & d_ack), 32'h0);
      check("ack_expected", 32'(sb.size() != 0), 32'h1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("ack_kind", 32'(d_ack), 32'(mon_e.is_d));
        check("ack_cycle", cyc, mon_e.cyc);
        if (mon_e.chk) check("ack_rdata", mon_e.is_d ? d_rdata : i_rdata, mon_e.data);
      end
    end
  end

  initial begin
    int unsigned n;
    bit          got;
    bit          pat [6];
    int          dn, inn;

    reset_n = 1'b1;
    i_req = 0; i_addr = 0; i_flush = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    #2 reset_n = 1'b0;
    #1;
    check("rst_busy",    32'(busy),     32'h0);
    check("rst_mem_en",  32'(mem_en),   32'h0);
    check("rst_mem_we",  32'(mem_we),   32'h0);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    check("rst_i_ack",   32'(i_ack),    32'h0);
    check("rst_d_ack",   32'(d_ack),    32'h0);
    check("rst_i_rdata", i_rdata,       32'h0);
    check("rst_d_rdata", d_rdata,       32'h0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    step();

    // Lone fetch of word 5
    n = cyc; i_req = 1; i_addr = 32'd5;
    push(0, 1, 32'h2800_0001, n + 3);
    step();
    check("fetch_mem_en",   32'(mem_en),   32'h1);
    check("fetch_mem_addr", 32'(mem_addr), 32'h5);
    check("fetch_mem_we",   32'(mem_we),   32'h0);
    wait_ack(0, 10, got); i_req = 0;
    step();
    check("idle_after_fetch", 32'(busy), 32'h0);

    // Store then load word 7 (load uses an address with high bits set)
    n = cyc; d_req = 1; d_we = 1; d_addr = 32'd7; d_wdata = 32'hDEAD_BEEF;
    push(1, 0, 32'h0, n + 3);
    step();
    check("store_mem_we",    32'(mem_we),   32'h1);
    check("store_mem_wdata", mem_wdata,     32'hDEAD_BEEF);
    check("store_mem_addr",  32'(mem_addr), 32'h7);
    step();
    check("store_we_one_cycle", 32'(mem_we), 32'h0);
    wait_ack(1, 10, got); d_req = 0; d_we = 0; d_wdata = 0;
    step();
    n = cyc; d_req = 1; d_addr = 32'hFFFF_FC07;
    push(1, 1, 32'hDEAD_BEEF, n + 3);
    wait_ack(1, 10, got); d_req = 0;
    step();

    // Simultaneous I and D: D first, I three cycles later, no idle gap
    n = cyc; i_req = 1; i_addr = 32'd0; d_req = 1; d_addr = 32'd20;
    push(1, 1, mem_pat(10'd20), n + 3);
    push(0, 1, mem_pat(10'd0),  n + 6);
    wait_ack(1, 10, got); d_req = 0;
    step();
    check("b2b_mem_en",   32'(mem_en),   32'h1);
    check("b2b_mem_addr", 32'(mem_addr), 32'h0);
    wait_ack(0, 10, got); i_req = 0;
    step();

    // Flush during WAIT of a fetch, with a D request arriving meanwhile
    n = cyc; i_req = 1; i_addr = 32'd9;
    step();
    step();
    i_flush = 1; i_req = 0; d_req = 1; d_addr = 32'd30;
    push(1, 1, mem_pat(10'd30), n + 6);
    step();
    i_flush = 0;
    check("flush_no_i_ack",   32'(i_ack), 32'h0);
    check("flush_rdata_hold", i_rdata,    mem_pat(10'd0));
    wait_ack(1, 10, got); d_req = 0;
    check("flush_rdata_hold2", i_rdata, mem_pat(10'd0));
    step();
    check("idle_after_flush", 32'(busy), 32'h0);

    // Flush while D owns the port has no effect
    n = cyc; d_req = 1; d_addr = 32'd7;
    push(1, 1, 32'hDEAD_BEEF, n + 3);
    step();
    step();
    i_flush = 1;
    wait_ack(1, 10, got); i_flush = 0; d_req = 0;
    step();

    // Flush in the grant cycle keeps I out; wrapped address 0x405 -> word 5
    n = cyc; i_req = 1; i_addr = 32'h0000_0405; i_flush = 1;
    step();
    check("flush_blocks_grant", 32'(busy), 32'h0);
    i_flush = 0;
    push(0, 1, mem_pat(10'd5), n + 4);
    wait_ack(0, 10, got); i_req = 0;
    step();

    // Continuous D with a pending fetch
`ifdef MEM_ARB_FAIRNESS_EN
    pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
`else
    pat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
    n = cyc; i_req = 1; i_addr = 32'd40; d_req = 1; d_we = 0; d_addr = 32'd100;
    dn = 0; inn = 0;
    for (int k = 0; k < 6; k++) begin
      if (pat[k]) begin
        push(1, 1, mem_pat(10'(100 + dn)), n + 3 * (k + 1)); dn++;
      end else begin
        push(0, 1, mem_pat(10'(40 + inn)), n + 3 * (k + 1)); inn++;
      end
    end
    for (int k = 0; k < 6; k++) begin
      wait_any(10, got);
      if (d_ack) d_addr = d_addr + 1;
      if (i_ack) i_addr = i_addr + 1;
    end
`ifdef MEM_ARB_FAIRNESS_EN
    i_req = 0; d_req = 0;
`else
    d_req = 0;
    push(0, 1, mem_pat(10'd40), n + 21);
    wait_ack(0, 10, got); i_req = 0;
`endif
    step();

    // Reset in WAIT abandons the fetch; a new one is served normally
    n = cyc; i_req = 1; i_addr = 32'd3;
    step();
    step();
    check("wait_busy", 32'(busy), 32'h1);
    reset_n = 0; i_req = 0;
    #1;
    check("mid_rst_busy",    32'(busy),   32'h0);
    check("mid_rst_mem_en",  32'(mem_en), 32'h0);
    check("mid_rst_i_ack",   32'(i_ack),  32'h0);
    check("mid_rst_i_rdata", i_rdata,     32'h0);
    check("mid_rst_d_rdata", d_rdata,     32'h0);
    @(posedge clock); #1 reset_n = 1;
    repeat (5) step();
    check("no_resume_busy", 32'(busy), 32'h0);
    n = cyc; i_req = 1; i_addr = 32'd6;
    push(0, 1, mem_pat(10'd6), n + 3);
    wait_ack(0, 10, got); i_req = 0;
    repeat (3) step();

    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
